player_cmd_arbiter: RTL and testbench

- Converts the two 5-bit held-key buses from player input logic into discrete move/action commands.
- Generates press and auto-repeat events for each player and buffers them in a per-player 2-entry queue.
- Round-robin arbitrates both players onto a single valid/ready command port that drives the shared game-state update logic.
- Sits between player_input and the game logic.

---
 rtl/player_cmd_arbiter_pkg.sv | 37 +++
 rtl/player_cmd_arbiter_queue.sv | 86 ++++++++
 rtl/player_cmd_arbiter.sv | 81 ++++++++
 tb/tb_player_cmd_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/player_cmd_arbiter_pkg.sv
// player_cmd_arbiter_pkg: command codes, key bit positions and player ids shared by the arbiter
package player_cmd_arbiter_pkg;

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_UP     = 3'd1;
    localparam logic [2:0] CMD_LEFT   = 3'd2;
    localparam logic [2:0] CMD_DOWN   = 3'd3;
    localparam logic [2:0] CMD_RIGHT  = 3'd4;
    localparam logic [2:0] CMD_ACTION = 3'd5;

    localparam int KEY_UP     = 4;
    localparam int KEY_LEFT   = 3;
    localparam int KEY_DOWN   = 2;
    localparam int KEY_RIGHT  = 1;
    localparam int KEY_ACTION = 0;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    // Highest-priority newly pressed key: action > up > down > left > right
    function automatic logic [2:0] press_code(input logic [4:0] np);
        return np[KEY_ACTION] ? CMD_ACTION :
               np[KEY_UP]     ? CMD_UP     :
               np[KEY_DOWN]   ? CMD_DOWN   :
               np[KEY_LEFT]   ? CMD_LEFT   :
               np[KEY_RIGHT]  ? CMD_RIGHT  : CMD_NONE;
    endfunction

    // Current level of the key that produces a given direction code
    function automatic logic key_of(input logic [4:0] keys, input logic [2:0] code);
        return code == CMD_UP    ? keys[KEY_UP]    :
               code == CMD_LEFT  ? keys[KEY_LEFT]  :
               code == CMD_DOWN  ? keys[KEY_DOWN]  :
               code == CMD_RIGHT ? keys[KEY_RIGHT] : 1'b0;
    endfunction

endpackage

// File: rtl/player_cmd_arbiter_queue.sv
// player_event_queue: per-player key sampling, press/repeat event generation and 2-deep command FIFO
module player_event_queue
    import player_cmd_arbiter_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int CNT_W         = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] keys,
    input  logic       enable,
    input  logic       pop,
    output logic       empty,
    output logic [2:0] head,
    output logic       overflow
);

    logic [4:0]       s1, s2;
    logic [2:0]       trk, pcode, ev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       q0, q1;
    logic [1:0]       count, n;
    logic             held, rep, is_dir, ovf;

    // Select this cycle's event: a new press beats a repeat expiry
    always_comb begin
        pcode  = press_code(s1 & ~s2);
        held   = key_of(s1, trk);
        rep    = held && cnt == '0;
        is_dir = pcode != CMD_NONE && pcode != CMD_ACTION;
        ev     = pcode != CMD_NONE ? pcode : rep ? trk : CMD_NONE;
        n      = count - {1'b0, pop};
    end

    // Input sampling and repeat tracking of the last pressed direction
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1  <= '0;
            s2  <= '0;
            trk <= CMD_NONE;
            cnt <= '0;
        end else begin
            s1 <= keys;
            s2 <= s1;
            if (!enable) begin
                trk <= CMD_NONE;
            end else if (is_dir) begin
                trk <= pcode;
                cnt <= CNT_W'(REPEAT_DELAY - 1);
            end else if (!held) begin
                trk <= CMD_NONE;
            end else begin
                cnt <= rep ? CNT_W'(REPEAT_PERIOD - 1) : cnt - CNT_W'(1);
            end
        end
    end

    // Two-entry FIFO; a pop frees a slot for a same-cycle push, pause flushes it
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
            q0    <= CMD_NONE;
            q1    <= CMD_NONE;
            ovf   <= 1'b0;
        end else if (!enable) begin
            count <= '0;
        end else begin
            if (pop) q0 <= q1;
            if (ev == CMD_NONE) begin
                count <= n;
            end else if (n == 2'd2) begin
                ovf <= 1'b1;
            end else begin
                count <= n + 2'd1;
                if (n == 2'd0) q0 <= ev;
                else q1 <= ev;
            end
        end
    end

    assign empty    = count == 2'd0;
    assign head     = q0;
    assign overflow = ovf;

endmodule

// File: rtl/player_cmd_arbiter.sv
// player_cmd_arbiter: round-robin merge of both players' command queues onto one valid/ready port
module player_cmd_arbiter
    import player_cmd_arbiter_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int CNT_W         = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] p1_input,
    input  logic [4:0] p2_input,
    input  logic       enable,
    output logic       cmd_valid,
    output logic       cmd_player,
    output logic [2:0] cmd_code,
    input  logic       cmd_ready,
    output logic       p1_overflow,
    output logic       p2_overflow
);

    logic       e1, e2, pop1, pop2, ptr, load, any, grant;
    logic [2:0] h1, h2;

    player_event_queue #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD),
        .CNT_W        (CNT_W)
    ) u_p1 (
        .clk     (clk),
        .rst     (rst),
        .keys    (p1_input),
        .enable  (enable),
        .pop     (pop1),
        .empty   (e1),
        .head    (h1),
        .overflow(p1_overflow)
    );

    player_event_queue #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD),
        .CNT_W        (CNT_W)
    ) u_p2 (
        .clk     (clk),
        .rst     (rst),
        .keys    (p2_input),
        .enable  (enable),
        .pop     (pop2),
        .empty   (e2),
        .head    (h2),
        .overflow(p2_overflow)
    );

    // Grant the favoured player when both wait, otherwise whoever has a head
    always_comb begin
        load  = !cmd_valid || cmd_ready;
        any   = !e1 || !e2;
        grant = (!e1 && !e2) ? ptr : (e1 ? P2 : P1);
        pop1  = load && any && grant == P1;
        pop2  = load && any && grant == P2;
    end

    // Output register refills only when empty or being accepted, so it never drops a command
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_valid  <= 1'b0;
            cmd_player <= P1;
            cmd_code   <= CMD_NONE;
            ptr        <= P1;
        end else if (load) begin
            cmd_valid <= any;
            if (any) begin
                cmd_player <= grant;
                cmd_code   <= grant == P2 ? h2 : h1;
                ptr        <= ~grant;
            end
        end
    end

endmodule

// File: tb/tb_player_cmd_arbiter.sv
// tb_player_cmd_arbiter: table vectors, directed corner sequences and a randomized run against a reference model
module tb_player_cmd_arbiter;

    localparam int D = 8;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] p1_input = '0;
    logic [4:0] p2_input = '0;
    logic       enable = 1'b1;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid, cmd_player, p1_overflow, p2_overflow;
    logic [2:0] cmd_code;

    int vecs = 0;
    int miss = 0;

    always #5 clk = ~clk;

    player_cmd_arbiter #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .p1_input   (p1_input),
        .p2_input   (p2_input),
        .enable     (enable),
        .cmd_valid  (cmd_valid),
        .cmd_player (cmd_player),
        .cmd_code   (cmd_code),
        .cmd_ready  (cmd_ready),
        .p1_overflow(p1_overflow),
        .p2_overflow(p2_overflow)
    );

    // Reference model: queues as small arrays, repeats scheduled from the press time
    logic       mv, mp, mov [2];
    int         mc, mptr, mcyc;
    int         mqd [2][2];
    int         mqn [2];
    logic [4:0] ms1 [2], ms2 [2];
    int         mtrk [2], mpc [2];

    task automatic model_clock();
        logic [4:0] np, keys;
        int code, ev, age, g;
        logic held;
        if (!rst) begin
            mv = 0; mp = 0; mc = 0; mptr = 0;
            for (int i = 0; i < 2; i++) begin
                mqn[i] = 0; mov[i] = 0; ms1[i] = 0; ms2[i] = 0; mtrk[i] = 0; mpc[i] = 0;
            end
        end else begin
            if (!mv || cmd_ready) begin
                if (mqn[0] > 0 || mqn[1] > 0) begin
                    g = (mqn[0] > 0 && mqn[1] > 0) ? mptr : (mqn[0] > 0 ? 0 : 1);
                    mv = 1; mp = g[0]; mc = mqd[g][0];
                    mqd[g][0] = mqd[g][1];
                    mqn[g]--;
                    mptr = 1 - g;
                end else mv = 0;
            end
            for (int pl = 0; pl < 2; pl++) begin
                keys = pl == 0 ? p1_input : p2_input;
                np = ms1[pl] & ~ms2[pl];
                code = np[0] ? 5 : np[4] ? 1 : np[2] ? 3 : np[3] ? 2 : np[1] ? 4 : 0;
                held = mtrk[pl] != 0 && ms1[pl][5 - mtrk[pl]];
                age = mcyc - mpc[pl];
                ev = code != 0 ? code : (held && age >= D && (age - D) % P == 0) ? mtrk[pl] : 0;
                if (enable) begin
                    if (ev != 0) begin
                        if (mqn[pl] < 2) begin
                            mqd[pl][mqn[pl]] = ev;
                            mqn[pl]++;
                        end else mov[pl] = 1;
                    end
                    if (code >= 1 && code <= 4) begin
                        mtrk[pl] = code; mpc[pl] = mcyc;
                    end else if (!held) mtrk[pl] = 0;
                end else begin
                    mqn[pl] = 0; mtrk[pl] = 0;
                end
                ms2[pl] = ms1[pl];
                ms1[pl] = keys;
            end
        end
        mcyc++;
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_port(input string nm, input logic v, input int pl, input int c);
        chk({nm, "_valid"}, int'(cmd_valid), int'(v));
        if (v) begin
            chk({nm, "_player"}, int'(cmd_player), pl);
            chk({nm, "_code"}, int'(cmd_code), c);
        end
    endtask

    task automatic do_reset();
        rst = 0; p1_input = 0; p2_input = 0; enable = 1; cmd_ready = 0;
        tick();
        rst = 1;
    endtask

    typedef struct {
        logic [4:0] a, b;
        logic       ev, ep;
        logic [2:0] ec;
    } vec_t;

    vec_t tbl [10];
    logic [4:0] bp [8];
    int b;

    initial begin
        tbl[0] = '{5'b01000, 5'b00010, 0, 0, 0};
        tbl[1] = '{5'b01000, 5'b00010, 0, 0, 0};
        tbl[2] = '{5'b00000, 5'b00000, 1, 0, 2};
        tbl[3] = '{5'b00000, 5'b00000, 1, 1, 4};
        tbl[4] = '{5'b00000, 5'b00000, 0, 0, 0};
        tbl[5] = '{5'b00001, 5'b00001, 0, 0, 0};
        tbl[6] = '{5'b00001, 5'b00001, 0, 0, 0};
        tbl[7] = '{5'b00000, 5'b00000, 1, 0, 5};
        tbl[8] = '{5'b00000, 5'b00000, 1, 1, 5};
        tbl[9] = '{5'b00000, 5'b00000, 0, 0, 0};
        bp = '{5'b10000, 5'b0, 5'b00100, 5'b0, 5'b01000, 5'b0, 5'b00010, 5'b0};
        mcyc = 0;

        do_reset();
        chk("reset_valid", int'(cmd_valid), 0);
        chk("reset_player", int'(cmd_player), 0);
        chk("reset_code", int'(cmd_code), 0);
        chk("reset_ovf1", int'(p1_overflow), 0);
        chk("reset_ovf2", int'(p2_overflow), 0);

        cmd_ready = 1;
        for (int i = 0; i < 10; i++) begin
            p1_input = tbl[i].a; p2_input = tbl[i].b;
            tick();
            chk_port($sformatf("contend%0d", i), tbl[i].ev, int'(tbl[i].ep), int'(tbl[i].ec));
        end

        do_reset();
        cmd_ready = 1;
        for (int j = 0; j < 25; j++) begin
            p1_input = j < 20 ? 5'b10000 : 5'b0;
            tick();
            chk_port($sformatf("repeat%0d", j), j == 2 || j == 10 || j == 14 || j == 18, 0, 1);
        end

        do_reset();
        for (int j = 0; j < 8; j++) begin
            p1_input = bp[j];
            tick();
            chk_port($sformatf("bp%0d", j), j >= 2, 0, 1);
            chk($sformatf("bp_ovf%0d", j), int'(p1_overflow), int'(j == 7));
        end
        cmd_ready = 1;
        tick(); chk_port("bp_drain0", 1, 0, 3);
        tick(); chk_port("bp_drain1", 1, 0, 2);
        tick(); chk_port("bp_drain2", 0, 0, 0);
        chk("bp_ovf_sticky", int'(p1_overflow), 1);
        chk("bp_ovf2", int'(p2_overflow), 0);

        do_reset();
        cmd_ready = 1;
        for (int j = 0; j < 10; j++) begin
            p2_input = j < 6 ? 5'b11001 : 5'b0;
            tick();
            chk_port($sformatf("prio%0d", j), j == 2, 1, 5);
        end

        do_reset();
        for (int j = 0; j < 14; j++) begin
            p1_input = j < 6 ? bp[j] : 5'b0;
            enable = !(j >= 6 && j < 9);
            cmd_ready = j >= 8;
            tick();
            chk_port($sformatf("pause%0d", j), j >= 2 && j < 8, 0, 1);
        end

        do_reset();
        for (int j = 0; j < 8; j++) begin
            p1_input = bp[j];
            p2_input = j == 0 ? 5'b00001 : 5'b0;
            tick();
        end
        chk("midrst_pre_valid", int'(cmd_valid), 1);
        chk("midrst_pre_ovf", int'(p1_overflow), 1);
        rst = 0; p1_input = 0; p2_input = 0;
        tick();
        rst = 1; cmd_ready = 1;
        chk("midrst_valid", int'(cmd_valid), 0);
        chk("midrst_ovf1", int'(p1_overflow), 0);
        chk("midrst_ovf2", int'(p2_overflow), 0);
        for (int j = 0; j < 10; j++) begin
            tick();
            chk_port($sformatf("midrst%0d", j), 0, 0, 0);
        end

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            b = $urandom_range(0, 4);
            if ($urandom_range(0, 5) == 0) p1_input[b] = ~p1_input[b];
            b = $urandom_range(0, 4);
            if ($urandom_range(0, 5) == 0) p2_input[b] = ~p2_input[b];
            cmd_ready = ((c / 40) % 3 != 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
            enable = $urandom_range(0, 60) != 0;
            rst = $urandom_range(0, 700) != 0;
            tick();
            chk("rnd_valid", int'(cmd_valid), int'(mv));
            if (mv) begin
                chk("rnd_player", int'(cmd_player), int'(mp));
                chk("rnd_code", int'(cmd_code), mc);
            end
            chk("rnd_ovf1", int'(p1_overflow), int'(mov[0]));
            chk("rnd_ovf2", int'(p2_overflow), int'(mov[1]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
